// File: rtl/asteroid_renderer_if.sv
// Video timing, buttons and pixel/game status
// exchanged with the asteroid renderer.
interface asteroid_renderer_if;
  logic [9:0] HCounter;
  logic [9:0] VCounter;
  logic       hsync_in;
  logic       vsync_in;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       HSync;
  logic       VSync;
  logic [3:0] Red;
  logic [3:0] Green;
  logic [3:0] Blue;
  logic [7:0] score;
  logic       game_over;

  modport master (
    output HCounter,
    output VCounter,
    output hsync_in,
    output vsync_in,
    output btn_left,
    output btn_right,
    output btn_start,
    input  HSync,
    input  VSync,
    input  Red,
    input  Green,
    input  Blue,
    input  score,
    input  game_over
  );

  modport slave (
    input  HCounter,
    input  VCounter,
    input  hsync_in,
    input  vsync_in,
    input  btn_left,
    input  btn_right,
    input  btn_start,
    output HSync,
    output VSync,
    output Red,
    output Green,
    output Blue,
    output score,
    output game_over
  );
endinterface

// File: rtl/asteroid_renderer.sv
// Dodge-the-asteroids game: ship/asteroid state
// updated once per frame, pixel colour one clk behind.
module asteroid_renderer #(
  parameter int NUM_AST   = 4,
  parameter int AST_SIZE  = 16,
  parameter int SHIP_W    = 32,
  parameter int SHIP_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  asteroid_renderer_if.slave vid
);

  localparam logic [9:0] SHIP_MAX = 10'(640 - SHIP_W);
  localparam logic [9:0] STEP     = 10'(SHIP_STEP);
  localparam logic [9:0] SHIP_Y0  = 10'd440;
  localparam logic [9:0] SHIP_Y1  = 10'd455;
  localparam logic [15:0] SEED    = 16'hACE1;

  typedef enum logic {
    PLAY = 1'b0,
    HIT  = 1'b1
  } state_e;

  function automatic logic [9:0] rst_ax(input int i);
    return 10'(64 + 160 * i);
  endfunction

  function automatic logic [9:0] rst_ay(input int i);
    return 10'(120 * i);
  endfunction

  state_e      state_q;
  state_e      state_d;
  logic [9:0]  ship_x_q;
  logic [9:0]  ship_x_d;
  logic [9:0]  ast_x_q [NUM_AST];
  logic [9:0]  ast_x_d [NUM_AST];
  logic [9:0]  ast_y_q [NUM_AST];
  logic [9:0]  ast_y_d [NUM_AST];
  logic [7:0]  score_q;
  logic [7:0]  score_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic [11:0] rgb_q;
  logic [11:0] rgb_d;
  logic        hs_q;
  logic        vs_q;
  logic        go_q;

  logic        visible;
  logic        tick;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        left_s;
  logic        right_s;
  logic        start_s;
  logic        on_ship;
  logic        on_ast;
  logic        collide;
  logic        fb;

  logic [9:0]         ast_ny [NUM_AST];
  logic [9:0]         ast_r  [NUM_AST];
  logic [9:0]         ast_rx [NUM_AST];
  logic [NUM_AST-1:0] ast_wrap;
  logic [NUM_AST-1:0] ast_cov;

  assign visible = (vid.HCounter >= 10'd144)
                && (vid.HCounter <= 10'd783)
                && (vid.VCounter >= 10'd36)
                && (vid.VCounter <= 10'd515);

  assign px   = vid.HCounter - 10'd144;
  assign py   = vid.VCounter - 10'd36;
  assign tick = (vid.HCounter == '0)
             && (vid.VCounter == '0);

  assign left_s  = sync2_q[0];
  assign right_s = sync2_q[1];
  assign start_s = sync2_q[2];

  // taps 16,14,13,11 as a right-shifting register
  assign fb     = lfsr_q[0] ^ lfsr_q[2]
                ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d = {fb, lfsr_q[15:1]};

  for (genvar gi = 0; gi < NUM_AST; gi++) begin : g_ast
    assign ast_ny[gi]   = ast_y_q[gi] + 10'(gi + 1);
    assign ast_wrap[gi] = ast_ny[gi] >= 10'd480;
    assign ast_r[gi]    = lfsr_q[9:0] ^ 10'(gi * 'h0A5);
    assign ast_rx[gi]   = (ast_r[gi] < 10'd624)
                        ? ast_r[gi]
                        : ast_r[gi] - 10'd512;
    assign ast_cov[gi]  = (px >= ast_x_q[gi])
      && ({1'b0, px} < {1'b0, ast_x_q[gi]} + 11'(AST_SIZE))
      && (py >= ast_y_q[gi])
      && ({1'b0, py} < {1'b0, ast_y_q[gi]} + 11'(AST_SIZE));
  end

  assign on_ship = visible
    && (px >= ship_x_q)
    && ({1'b0, px} < {1'b0, ship_x_q} + 11'(SHIP_W))
    && (py >= SHIP_Y0)
    && (py <= SHIP_Y1);

  assign on_ast  = visible && (|ast_cov);
  assign collide = (state_q == PLAY) && on_ship && on_ast;

  always_comb begin
    state_d  = state_q;
    ship_x_d = ship_x_q;
    ast_x_d  = ast_x_q;
    ast_y_d  = ast_y_q;
    score_d  = score_q;
    unique case (state_q)
      PLAY: begin
        if (tick) begin
          unique case (1'b1)
            left_s && !right_s:
              ship_x_d = (ship_x_q < STEP)
                       ? '0 : ship_x_q - STEP;
            right_s && !left_s:
              ship_x_d = (ship_x_q > SHIP_MAX - STEP)
                       ? SHIP_MAX : ship_x_q + STEP;
            default: ;
          endcase
          for (int i = 0; i < NUM_AST; i++) begin
            ast_y_d[i] = ast_wrap[i] ? '0 : ast_ny[i];
            if (ast_wrap[i]) begin
              ast_x_d[i] = ast_rx[i];
              if (score_d != 8'hFF)
                score_d = score_d + 8'd1;
            end
          end
        end
        // a same-cycle tick still moves things first
        if (collide)
          state_d = HIT;
      end
      HIT: begin
        if (tick && start_s) begin
          ship_x_d = 10'd304;
          for (int i = 0; i < NUM_AST; i++) begin
            ast_x_d[i] = rst_ax(i);
            ast_y_d[i] = rst_ay(i);
          end
          score_d = '0;
          state_d = PLAY;
        end
      end
    endcase
  end

  always_comb begin
    rgb_d = '0;
    if (visible) begin
      if (state_q == HIT)
        rgb_d = 12'hF00;
      else if (on_ship)
        rgb_d = 12'h0F0;
      else if (on_ast)
        rgb_d = 12'h888;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {vid.btn_start,
                  vid.btn_right,
                  vid.btn_left};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      ship_x_q <= 10'd304;
      for (int i = 0; i < NUM_AST; i++) begin
        ast_x_q[i] <= rst_ax(i);
        ast_y_q[i] <= rst_ay(i);
      end
      score_q  <= '0;
      lfsr_q   <= SEED;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ship_x_q <= ship_x_d;
      ast_x_q  <= ast_x_d;
      ast_y_q  <= ast_y_d;
      score_q  <= score_d;
      lfsr_q   <= lfsr_d;
      go_q     <= (state_d == HIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= vid.hsync_in;
      vs_q  <= vid.vsync_in;
    end
  end

  assign vid.Red       = rgb_q[11:8];
  assign vid.Green     = rgb_q[7:4];
  assign vid.Blue      = rgb_q[3:0];
  assign vid.HSync     = hs_q;
  assign vid.VSync     = vs_q;
  assign vid.score     = score_q;
  assign vid.game_over = go_q;

endmodule

// File: tb/tb_asteroid_renderer.sv
// Bench for asteroid_renderer: vector table, directed
// game sequences and random pixels against a game model.
module tb_asteroid_renderer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  asteroid_renderer_if vif();

  asteroid_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // game model, in plain integers
  bit          m_hit;
  int          m_ship;
  int          m_ax [4];
  int          m_ay [4];
  int          m_score;
  int          m_lfsr;
  bit [2:0]    m_h1;
  bit [2:0]    m_h2;
  logic [11:0] m_rgb;
  bit          m_hs;
  bit          m_vs;

  typedef struct {
    int          h;
    int          v;
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl [14];

  function automatic void m_pos_reset();
    m_ship = 304;
    for (int i = 0; i < 4; i++) begin
      m_ax[i] = 64 + 160 * i;
      m_ay[i] = 120 * i;
    end
  endfunction

  function automatic void m_reset();
    m_pos_reset();
    m_hit   = 0;
    m_score = 0;
    m_lfsr  = 'hACE1;
    m_h1    = '0;
    m_h2    = '0;
    m_rgb   = '0;
    m_hs    = 0;
    m_vs    = 0;
  endfunction

  function automatic bit in_ship(input int x, input int y);
    return x >= m_ship && x < m_ship + 32 && y >= 440 && y <= 455;
  endfunction

  function automatic bit in_ast(input int x, input int y);
    bit r = 0;
    for (int i = 0; i < 4; i++)
      if (x >= m_ax[i] && x < m_ax[i] + 16 &&
          y >= m_ay[i] && y < m_ay[i] + 16)
        r = 1;
    return r;
  endfunction

  function automatic int overlap_idx();
    int r = -1;
    for (int i = 3; i >= 0; i--)
      if (m_ax[i] <= m_ship + 31 && m_ship <= m_ax[i] + 15 &&
          m_ay[i] <= 455 && 440 <= m_ay[i] + 15)
        r = i;
    return r;
  endfunction

  function automatic void m_edge(input int h, input int v,
                                 input bit hs, input bit vs,
                                 input bit [2:0] btn);
    bit vis = h >= 144 && h <= 783 && v >= 36 && v <= 515;
    int x = h - 144;
    int y = v - 36;
    bit s = vis && in_ship(x, y);
    bit a = vis && in_ast(x, y);
    bit was_hit = m_hit;
    bit [2:0] used = m_h2;
    logic [11:0] c = '0;
    int r;
    int fb;
    if (vis) begin
      if (was_hit) c = 12'hF00;
      else if (s)  c = 12'h0F0;
      else if (a)  c = 12'h888;
    end
    if (h == 0 && v == 0) begin
      if (!was_hit) begin
        if (used[0] && !used[1])
          m_ship = (m_ship - 4 < 0) ? 0 : m_ship - 4;
        else if (used[1] && !used[0])
          m_ship = (m_ship + 4 > 608) ? 608 : m_ship + 4;
        for (int i = 0; i < 4; i++) begin
          m_ay[i] += i + 1;
          if (m_ay[i] >= 480) begin
            m_ay[i] = 0;
            r = (m_lfsr % 1024) ^ (i * 'hA5);
            m_ax[i] = (r < 624) ? r : r - 512;
            if (m_score < 255) m_score++;
          end
        end
      end else if (used[2]) begin
        m_pos_reset();
        m_score = 0;
        m_hit = 0;
      end
    end
    if (!was_hit && s && a) m_hit = 1;
    m_rgb = c;
    m_hs  = hs;
    m_vs  = vs;
    m_h2  = m_h1;
    m_h1  = btn;
    fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
  endfunction

  function automatic logic [31:0] dut_pack();
    return {9'b0, vif.Red, vif.Green, vif.Blue,
            vif.HSync, vif.VSync, vif.game_over, vif.score};
  endfunction

  function automatic logic [31:0] mod_pack();
    return {9'b0, m_rgb, m_hs, m_vs, m_hit, 8'(m_score)};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic mcmp(input string nm);
    chk(nm, dut_pack(), mod_pack());
  endtask

  task automatic drive(input int h, input int v);
    vif.HCounter = 10'(h);
    vif.VCounter = 10'(v);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n)
      m_edge(int'(vif.HCounter), int'(vif.VCounter),
             vif.hsync_in, vif.vsync_in,
             {vif.btn_start, vif.btn_right, vif.btn_left});
    else
      m_reset();
    #1;
  endtask

  task automatic frame();
    drive(0, 0);
    step();
    drive(10, 10);
    step();
  endtask

  task automatic do_reset();
    vif.btn_left  = 0;
    vif.btn_right = 0;
    vif.btn_start = 0;
    drive(10, 10);
    rst_n = 0;
    m_reset();
    #1;
    chk("reset_outputs", dut_pack(), 32'h0);
    step();
    step();
    rst_n = 1;
  endtask

  task automatic probe(input string nm, input int x, input int y);
    drive(144 + x, 36 + y);
    step();
    mcmp(nm);
  endtask

  initial begin
    int k;
    int px;
    int py;
    tbl[0]  = '{448, 476, 1, 0, 12'h0F0};
    tbl[1]  = '{479, 491, 0, 1, 12'h0F0};
    tbl[2]  = '{480, 481, 1, 1, 12'h000};
    tbl[3]  = '{447, 481, 0, 0, 12'h000};
    tbl[4]  = '{448, 475, 1, 0, 12'h000};
    tbl[5]  = '{208,  36, 0, 1, 12'h888};
    tbl[6]  = '{223,  51, 1, 1, 12'h888};
    tbl[7]  = '{224,  36, 0, 0, 12'h000};
    tbl[8]  = '{368, 156, 1, 0, 12'h888};
    tbl[9]  = '{703, 411, 0, 1, 12'h888};
    tbl[10] = '{528, 276, 1, 1, 12'h888};
    tbl[11] = '{784, 100, 0, 0, 12'h000};
    tbl[12] = '{100, 481, 1, 0, 12'h000};
    tbl[13] = '{448, 516, 0, 1, 12'h000};

    vif.hsync_in  = 1;
    vif.vsync_in  = 1;
    vif.btn_left  = 0;
    vif.btn_right = 0;
    vif.btn_start = 0;
    drive(10, 10);
    rst_n = 0;
    m_reset();
    #1;
    chk("reset_outputs", dut_pack(), 32'h0);
    step();
    step();
    rst_n = 1;

    // first clk after release
    drive(400, 300);
    vif.hsync_in = 1;
    vif.vsync_in = 0;
    step();
    chk("rel_rgb", {vif.Red, vif.Green, vif.Blue}, 12'h000);
    chk("rel_sync", {vif.HSync, vif.VSync}, 2'b10);
    mcmp("rel_model");

    drive(144 + 304, 36 + 445);
    step();
    chk("ship_px_green", vif.Green, 4'hF);
    drive(100, 36 + 445);
    step();
    chk("hblank_black", {vif.Red, vif.Green, vif.Blue}, 12'h000);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].h, tbl[i].v);
      vif.hsync_in = tbl[i].hs;
      vif.vsync_in = tbl[i].vs;
      step();
      chk($sformatf("tbl%0d", i),
          {vif.Red, vif.Green, vif.Blue, vif.HSync, vif.VSync},
          {tbl[i].rgb, tbl[i].hs, tbl[i].vs});
      mcmp($sformatf("tbl%0d_model", i));
    end

    // ship to the right wall
    do_reset();
    vif.btn_right = 1;
    step();
    step();
    for (int i = 0; i < 80; i++) frame();
    drive(144 + 608, 36 + 445);
    step();
    chk("right_edge_green", {vif.Red, vif.Green, vif.Blue}, 12'h0F0);
    frame();
    probe("right_t81_639", 639, 445);
    probe("right_t81_607", 607, 445);

    // ship to the left wall
    do_reset();
    vif.btn_left = 1;
    step();
    step();
    for (int i = 0; i < 80; i++) frame();
    drive(144, 36 + 445);
    step();
    chk("left_edge_green", {vif.Red, vif.Green, vif.Blue}, 12'h0F0);
    probe("left_31", 31, 445);
    probe("left_32", 32, 445);

    // asteroid wrap, respawn and score saturation
    do_reset();
    for (int i = 0; i < 480; i++) frame();
    chk("score_480", vif.score, 8'd10);
    mcmp("wrap_model");
    drive(144 + m_ax[0], 36);
    step();
    chk("ast0_respawn", {vif.Red, vif.Green, vif.Blue}, 12'h888);
    chk("ast0_x_range", 32'(m_ax[0] < 624), 32'd1);
    for (int i = 0; i < 12000; i++) frame();
    chk("score_sat", vif.score, 8'd255);
    mcmp("sat_model");

    // drive the ship under asteroid 1, then find first overlap
    do_reset();
    vif.btn_left = 1;
    step();
    step();
    for (int i = 0; i < 20; i++) frame();
    vif.btn_left = 0;
    step();
    step();
    k = 0;
    while (overlap_idx() < 0 && k < 400) begin
      frame();
      k++;
    end
    if (overlap_idx() < 0) begin
      chk("overlap_found", 32'd0, 32'd1);
    end else begin
      px = (m_ax[overlap_idx()] > m_ship) ? m_ax[overlap_idx()] : m_ship;
      py = (m_ay[overlap_idx()] > 440) ? m_ay[overlap_idx()] : 440;
      chk("pre_hit_go", vif.game_over, 1'b0);
      drive(144 + px, 36 + py);
      step();
      chk("hit_px_green", {vif.Red, vif.Green, vif.Blue}, 12'h0F0);
      chk("go_1clk", vif.game_over, 1'b1);
      step();
      chk("hit_red", {vif.Red, vif.Green, vif.Blue}, 12'hF00);
      mcmp("hit_model");
      for (int i = 0; i < 5; i++) frame();
      mcmp("hit_frozen");
      probe("hit_other_px", 10, 10);
      vif.btn_start = 1;
      drive(10, 10);
      step();
      step();
      step();
      drive(0, 0);
      step();
      chk("restart_go", vif.game_over, 1'b0);
      chk("restart_score", vif.score, 8'd0);
      vif.btn_start = 0;
      drive(144 + 304, 36 + 445);
      step();
      chk("restart_ship", {vif.Red, vif.Green, vif.Blue}, 12'h0F0);
      mcmp("restart_model");
    end

    // random pixels, buttons and frame ticks
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_n = 0;
        m_reset();
        #1;
        mcmp("rnd_reset");
        step();
        step();
        rst_n = 1;
      end
      k = $urandom_range(0, 7);
      if (k == 0)
        drive(0, 0);
      else if (k < 4)
        drive($urandom_range(0, 799), $urandom_range(0, 524));
      else
        drive(144 + $urandom_range(0, 639), 476 + $urandom_range(0, 15));
      vif.hsync_in  = 1'($urandom_range(0, 1));
      vif.vsync_in  = 1'($urandom_range(0, 1));
      vif.btn_left  = ($urandom_range(0, 2) == 0);
      vif.btn_right = ($urandom_range(0, 2) == 0);
      vif.btn_start = ($urandom_range(0, 7) == 0);
      step();
      mcmp("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/asteroid_renderer.md
ASTEROID_RENDERER -- requirements
Module: asteroid_renderer

Interface
- REQ-001 Parameter NUM_AST, 4, number of asteroids (1..4).
- REQ-002 Parameter AST_SIZE, 16, asteroid square edge in pixels.
- REQ-003 Parameter SHIP_W, 32, ship width in pixels; ship height fixed at 16.
- REQ-004 Parameter SHIP_STEP, 4, ship pixels moved per frame.
- REQ-005 clk  in  1  pixel clock (25 MHz divided clock), all state on rising edge.
- REQ-006 rst_n  in  1  asynchronous, active-low reset.
- REQ-007 HCounter  in  10  horizontal count from timing stage, 0..799.
- REQ-008 VCounter  in  10  vertical count from timing stage, 0..524.
- REQ-009 hsync_in, vsync_in  in  1 each  syncs from timing stage, aligned with the counters.
- REQ-010 btn_left, btn_right, btn_start  in  1 each  asynchronous, debounced, active-high buttons.
- REQ-011 HSync, VSync  out  1 each  sync inputs delayed exactly 1 clk.
- REQ-012 Red, Green, Blue  out  4 each  registered pixel colour, 1 clk latency.
- REQ-013 score  out  8  asteroids dodged, saturating.
- REQ-014 game_over  out  1  high while in HIT state.

Function
- REQ-015 Visible window SHALL be HCounter 144..783, VCounter 36..515; px=HCounter-144, py=VCounter-36 (0..639, 0..479).
- REQ-016 Buttons SHALL pass through a 2-flop synchroniser before use.
- REQ-017 Frame tick SHALL be the single cycle where HCounter==0 and VCounter==0; all position, score and state updates occur only on it, except PLAY->HIT.
- REQ-018 States: PLAY, HIT; reset state PLAY.
- REQ-019 PLAY, tick: left only -> ship_x -= SHIP_STEP clamped to 0; right only -> ship_x += SHIP_STEP clamped to 640-SHIP_W; both or neither -> unchanged.
- REQ-020 Ship occupies ship_x..ship_x+SHIP_W-1, py 440..455.
- REQ-021 PLAY, tick: asteroid i y += (i+1); if new y >= 480, then y=0, x=respawn value, score += 1 saturating at 255.
- REQ-022 Respawn x SHALL be r = lfsr[9:0] XOR (i*10'h0A5); x = r if r < 624, else r-512.
- REQ-023 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every clk in both states, never all-zero.
- REQ-024 Asteroid i occupies x..x+AST_SIZE-1, y..y+AST_SIZE-1; pixels with y beyond 479 are not drawn.
- REQ-025 PLAY, visible pixel covered by ship and any asteroid SHALL move state to HIT on the next clk; score frozen from then.
- REQ-026 HIT: positions and score frozen; at a tick with synchronised btn_start=1, SHALL reload reset positions, clear score, and return to PLAY.
- REQ-027 Colour priority, registered: outside visible -> 0/0/0; HIT visible -> F/0/0; ship -> 0/F/0; asteroid -> 8/8/8; else 0/0/0.
- REQ-028 Collision and tick in the same cycle: tick updates apply first, then state -> HIT.
- REQ-029 Multiple asteroids respawning on one tick SHALL each add 1 to score, saturating.
- REQ-030 game_over SHALL be registered state decode, 0 in PLAY.

Reset
- REQ-031 rst_n low SHALL immediately clear Red/Green/Blue, HSync, VSync, score, game_over and synchroniser flops to 0.
- REQ-032 Reset values: ship_x=304; asteroid i x=64+160*i, y=120*i; lfsr=16'hACE1; state PLAY.
- REQ-033 Reset asserted mid-frame SHALL abort rendering; first tick after release uses reset positions.

Verification
- REQ-034 Reset release, counters at (400,300) -> next clk Red=Green=Blue=0, HSync/VSync equal previous-cycle inputs.
- REQ-035 Hold btn_right for 80 ticks -> ship_x=608 and stays 608 at tick 81; btn_left 80 ticks -> 0.
- REQ-036 Asteroid 0 from y=0, 480 ticks, no hit -> y wraps to 0, score=1, new x < 624.
- REQ-037 Force asteroid over ship (x=304,y=436) in PLAY -> game_over=1 one clk after first overlap pixel; visible pixels F/0/0 from then.
- REQ-038 HIT, btn_start high 3 clk before a tick -> at tick reset positions, score=0, game_over=0.
- REQ-039 Pixel (HCounter=144+304, VCounter=36+445) with ship at reset -> Green=F one clk later; HCounter=100 -> all 0.
